// File: rtl/frame_pkg.sv
// Shared frame packing definitions: lane count, count width, FSM states and
// the lane slice position used by both the packer and the reduction stage.
package frame_pkg;

  typedef enum logic {
    FILLING = 1'b0,
    PENDING = 1'b1
  } fill_state_e;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } out_state_e;

  localparam int DEFAULT_SIZE = 2;

  function automatic int lanes(input int size);
    return 1 << size;
  endfunction

  function automatic int count_w(input int size);
    return size + 1;
  endfunction

  localparam int COUNT_W = count_w(DEFAULT_SIZE);

  // Lane i occupies [width*(i+1)-1 : width*i]; use as vec[lane_lsb(i, w) +: w].
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/frame_packer.sv
// Packs a serial sample stream into zero-padded frames of 2**SIZE lanes,
// with a fill register backing an output register so input can keep flowing.
//
// state       | meaning
// FILLING     | accepting samples into the fill register
// PENDING     | fill register holds a complete frame waiting for the output
// EMPTY       | output register free
// HOLD        | output register presents a frame (out_valid)
module frame_packer
  import frame_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SIZE  = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [WIDTH-1:0]                     in_data,
  input  logic                                 in_valid,
  input  logic                                 in_last,
  output logic                                 in_ready,
  output logic [lanes(SIZE)*WIDTH-1:0]         out_data,
  output logic [count_w(SIZE)-1:0]             out_count,
  output logic                                 out_valid,
  input  logic                                 out_ready
);

  localparam int LANES = lanes(SIZE);
  localparam int CNT_W = count_w(SIZE);
  localparam int FW    = LANES * WIDTH;
  localparam logic [SIZE-1:0] LAST_LANE = SIZE'(LANES - 1);

  fill_state_e       fill_state_q, fill_state_d;
  out_state_e        out_state_q, out_state_d;
  logic [SIZE-1:0]   ptr_q, ptr_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [CNT_W-1:0]  pend_count_q, pend_count_d;
  logic [FW-1:0]     out_data_q, out_data_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;

  logic              accept;
  logic              complete;
  logic              out_free;
  logic [FW-1:0]     frame_c;
  logic [CNT_W-1:0]  count_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_state_q <= FILLING;
      out_state_q  <= EMPTY;
      ptr_q        <= '0;
      fill_q       <= '0;
      pend_count_q <= '0;
      out_data_q   <= '0;
      out_count_q  <= '0;
    end else begin
      fill_state_q <= fill_state_d;
      out_state_q  <= out_state_d;
      ptr_q        <= ptr_d;
      fill_q       <= fill_d;
      pend_count_q <= pend_count_d;
      out_data_q   <= out_data_d;
      out_count_q  <= out_count_d;
    end
  end

  // Completed frame as it would look with the current sample in lane ptr_q:
  // earlier lanes from the fill register, later lanes zero.
  always_comb begin
    frame_c = '0;
    for (int i = 0; i < LANES; i++) begin
      if (SIZE'(i) < ptr_q) begin
        frame_c[lane_lsb(i, WIDTH) +: WIDTH] = fill_q[lane_lsb(i, WIDTH) +: WIDTH];
      end else if (SIZE'(i) == ptr_q) begin
        frame_c[lane_lsb(i, WIDTH) +: WIDTH] = in_data;
      end
    end
    count_c = CNT_W'(ptr_q) + CNT_W'(1);
  end

  always_comb begin
    fill_state_d = fill_state_q;
    out_state_d  = out_state_q;
    ptr_d        = ptr_q;
    fill_d       = fill_q;
    pend_count_d = pend_count_q;
    out_data_d   = out_data_q;
    out_count_d  = out_count_q;

    accept   = in_valid && in_ready;
    complete = accept && (in_last || (ptr_q == LAST_LANE));
    out_free = (out_state_q == EMPTY) || out_ready;

    if ((out_state_q == HOLD) && out_ready) begin
      out_state_d = EMPTY;
    end

    if (fill_state_q == PENDING) begin
      if (out_free) begin
        out_data_d   = fill_q;
        out_count_d  = pend_count_q;
        out_state_d  = HOLD;
        fill_state_d = FILLING;
        ptr_d        = '0;
      end
    end else if (complete) begin
      ptr_d = '0;
      if (out_free) begin
        out_data_d  = frame_c;
        out_count_d = count_c;
        out_state_d = HOLD;
      end else begin
        fill_d       = frame_c;
        pend_count_d = count_c;
        fill_state_d = PENDING;
      end
    end else if (accept) begin
      for (int i = 0; i < LANES; i++) begin
        if (SIZE'(i) == ptr_q) begin
          fill_d[lane_lsb(i, WIDTH) +: WIDTH] = in_data;
        end
      end
      ptr_d = ptr_q + SIZE'(1);
    end
  end

  always_comb begin
    in_ready  = (fill_state_q == FILLING);
    out_valid = (out_state_q == HOLD);
    out_data  = out_data_q;
    out_count = out_count_q;
  end

endmodule
